// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that time-shares one iterative binary-to-BCD converter
// between NUM_REQ requesters and returns each result tagged with its requester.
module bcd_conv_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BIN_WIDTH  = 32,
  parameter int NUM_DIGITS = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*BIN_WIDTH-1:0]  req_bin,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [$clog2(NUM_REQ)-1:0]    res_id,
  output logic [NUM_DIGITS*4-1:0]       res_bcd,
  output logic                          res_err,
  output logic                          conv_load,
  output logic [BIN_WIDTH-1:0]          conv_bin,
  input  logic                          conv_done,
  input  logic [NUM_DIGITS*4-1:0]       conv_bcd
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} stateT;

  stateT                state;
  logic [ID_W-1:0]      rrPtr;
  logic [CNT_W-1:0]     waitCnt;
  logic                 grantFound;
  logic [ID_W-1:0]      grantIdx;
  logic [BIN_WIDTH-1:0] grantBin;

  function automatic int wrapIdx(input logic [ID_W-1:0] base, input int off);
    return (int'(base) + off) % NUM_REQ;
  endfunction

  // NOTE: scanning from the farthest offset down lets the last hit, i.e. the
  // one closest to rrPtr, win; every variable gets a default so no latch forms.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    grantBin   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrapIdx(rrPtr, k)]) begin
        grantFound = 1'b1;
        grantIdx   = ID_W'(wrapIdx(rrPtr, k));
        grantBin   = req_bin[wrapIdx(rrPtr, k)*BIN_WIDTH +: BIN_WIDTH];
      end
    end
  end

  // Accept is combinational so the requester sees it in its request cycle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grantFound && !rst)
      req_ready[grantIdx] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments only; the async reset clears every
  // register so an aborted conversion leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rrPtr     <= '0;
      waitCnt   <= '0;
      res_id    <= '0;
      res_bcd   <= '0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
      conv_load <= 1'b0;
      conv_bin  <= '0;
    end else begin
      conv_load <= 1'b0;
      case (state)
        IDLE: begin
          if (grantFound) begin
            res_id    <= grantIdx;
            conv_bin  <= grantBin;
            conv_load <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          waitCnt <= waitCnt + 1'b1;
          // A completion on the final cycle still counts as success.
          if (conv_done) begin
            res_bcd   <= conv_bcd;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= RESP;
          end else if (waitCnt == LAST_CNT) begin
            res_bcd   <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            rrPtr     <= (res_id == LAST_ID) ? '0 : res_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: the bench plays the converter and the
// clients, with every expected value written out by hand.
module tb_bcd_conv_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int BIN_WIDTH  = 32;
  localparam int NUM_DIGITS = 10;
  localparam int TIMEOUT    = 16;

  logic                         clk;
  logic                         rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*BIN_WIDTH-1:0] req_bin;
  logic                         res_valid;
  logic                         res_ready;
  logic [1:0]                   res_id;
  logic [NUM_DIGITS*4-1:0]      res_bcd;
  logic                         res_err;
  logic                         conv_load;
  logic [BIN_WIDTH-1:0]         conv_bin;
  logic                         conv_done;
  logic [NUM_DIGITS*4-1:0]      conv_bcd;

  int total;
  int bad;
  int lat;
  int errs;

  bcd_conv_arbiter #(
    .NUM_REQ(NUM_REQ), .BIN_WIDTH(BIN_WIDTH), .NUM_DIGITS(NUM_DIGITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_bin(req_bin),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_bcd(res_bcd), .res_err(res_err),
    .conv_load(conv_load), .conv_bin(conv_bin),
    .conv_done(conv_done), .conv_bcd(conv_bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBin(input int idx, input logic [BIN_WIDTH-1:0] val);
    req_bin[idx*BIN_WIDTH +: BIN_WIDTH] = val;
  endtask

  // Called in the accept cycle; returns at the first cycle with res_valid
  // (or after a bounded wait) with latency counted from the accept cycle.
  // lat = cycles from load to done; lat = 0 means the converter never answers.
  task automatic runXfer(input int lat_cyc, input logic [39:0] bcd,
                         input logic [31:0] expBin, input logic [3:0] keepMask,
                         input bit strayLoad, output int latency);
    tick();
    latency = 1;
    check("conv_load_pulse", conv_load, 1);
    check("conv_bin", conv_bin, expBin);
    req_valid = req_valid & keepMask;
    if (strayLoad) begin
      conv_done = 1'b1;
      conv_bcd  = 40'h999;
    end
    tick();
    latency   = 2;
    conv_done = 1'b0;
    conv_bcd  = '0;
    check("conv_load_once", conv_load, 0);
    check("ready_busy", req_ready, 0);
    for (int i = 1; i < lat_cyc; i++) begin
      tick();
      latency++;
    end
    if (lat_cyc > 0) begin
      conv_done = 1'b1;
      conv_bcd  = bcd;
      tick();
      latency++;
      conv_done = 1'b0;
      conv_bcd  = '0;
    end
    while (!res_valid && latency < 60) begin
      tick();
      latency++;
    end
  endtask

  logic [39:0] expBcd [4] = '{40'h10, 40'h20, 40'h30, 40'h40};

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; req_valid = '0; req_bin = '0; res_ready = 1'b0;
    conv_done = 1'b0; conv_bcd = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_bcd", res_bcd, 0);
    check("rst_res_err", res_err, 0);
    check("rst_conv_load", conv_load, 0);
    check("rst_conv_bin", conv_bin, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single request from requester 2, converter answers 5 cycles after load.
    setBin(2, 32'd255);
    req_valid = 4'b0100;
    #1 check("t1_ready", req_ready, 4'b0100);
    runXfer(5, 40'h255, 32'd255, 4'b0000, 1'b0, lat);
    check("t1_latency", lat, 7);
    check("t1_valid", res_valid, 1);
    check("t1_id", res_id, 2);
    check("t1_bcd", res_bcd, 40'h0000000255);
    check("t1_err", res_err, 0);
    res_ready = 1'b1;
    tick();
    check("t1_valid_drop", res_valid, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // All four requesting continuously: round-robin order 0,1,2,3,0,1.
    for (int i = 0; i < 4; i++) setBin(i, 32'(10 * (i + 1)));
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 check("t2_ready", req_ready, 64'(1) << (k % 4));
      runXfer(3, expBcd[k % 4], 32'(10 * (k % 4 + 1)), 4'b1111, 1'b0, lat);
      check("t2_latency", lat, 5);
      check("t2_id", res_id, k % 4);
      check("t2_bcd", res_bcd, expBcd[k % 4]);
      check("t2_err", res_err, 0);
      tick();
      check("t2_valid_drop", res_valid, 0);
    end

    // Back-pressure: result held for 20 cycles, nothing else accepted.
    res_ready = 1'b0;
    #1 check("t3_ready", req_ready, 4'b0100);
    runXfer(3, 40'h30, 32'd30, 4'b1111, 1'b0, lat);
    check("t3_valid", res_valid, 1);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid !== 1'b1 || res_id !== 2'd2 || res_bcd !== 40'h30 ||
          res_err !== 1'b0 || req_ready !== 4'b0000 || conv_load !== 1'b0)
        errs++;
      tick();
    end
    check("t3_stable", errs, 0);
    res_ready = 1'b1;
    tick();
    #1 check("t3_next_grant", req_ready, 4'b1000);
    runXfer(2, 40'h40, 32'd40, 4'b0000, 1'b0, lat);
    check("t3_next_id", res_id, 3);
    check("t3_next_bcd", res_bcd, 40'h40);
    tick();

    // Timeout: converter never answers; a late done in IDLE is ignored.
    setBin(0, 32'd1234);
    req_valid = 4'b0001;
    #1 check("t4_ready", req_ready, 4'b0001);
    runXfer(0, 40'h0, 32'd1234, 4'b0000, 1'b0, lat);
    check("t4_latency", lat, 18);
    check("t4_valid", res_valid, 1);
    check("t4_err", res_err, 1);
    check("t4_bcd", res_bcd, 0);
    check("t4_id", res_id, 0);
    tick();
    check("t4_valid_drop", res_valid, 0);
    conv_done = 1'b1;
    conv_bcd  = 40'h999;
    tick();
    conv_done = 1'b0;
    conv_bcd  = '0;
    for (int i = 0; i < 3; i++) begin
      check("t4_late_done", res_valid, 0);
      tick();
    end

    // Done on the last WAIT cycle beats the timeout.
    setBin(1, 32'd77);
    req_valid = 4'b0010;
    #1 check("t5_ready", req_ready, 4'b0010);
    runXfer(TIMEOUT, 40'h77, 32'd77, 4'b0000, 1'b0, lat);
    check("t5_latency", lat, 18);
    check("t5_err", res_err, 0);
    check("t5_bcd", res_bcd, 40'h77);
    check("t5_id", res_id, 1);
    tick();

    // Stray done during LOAD and during RESP are both ignored.
    res_ready = 1'b0;
    setBin(2, 32'd500);
    req_valid = 4'b0100;
    #1 check("t5b_ready", req_ready, 4'b0100);
    runXfer(4, 40'h500, 32'd500, 4'b0000, 1'b1, lat);
    check("t5b_latency", lat, 6);
    check("t5b_bcd", res_bcd, 40'h500);
    conv_done = 1'b1;
    conv_bcd  = 40'h888;
    tick();
    conv_done = 1'b0;
    conv_bcd  = '0;
    check("t5b_resp_valid", res_valid, 1);
    check("t5b_resp_bcd", res_bcd, 40'h500);
    check("t5b_resp_err", res_err, 0);
    res_ready = 1'b1;
    tick();
    check("t5b_valid_drop", res_valid, 0);

    // Async reset in WAIT, then requester 3 alone with rr_ptr back at 0.
    setBin(0, 32'd5);
    req_valid = 4'b0001;
    #1 check("t6_ready", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0000;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_conv_bin", conv_bin, 0);
    check("t6_rst_valid", res_valid, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_load", conv_load, 0);
    tick();
    rst = 1'b0;
    tick();
    setBin(3, 32'hFFFF_FFFF);
    req_valid = 4'b1000;
    #1 check("t6_ready3", req_ready, 4'b1000);
    runXfer(5, 40'h4294967295, 32'hFFFF_FFFF, 4'b0000, 1'b0, lat);
    check("t6_latency", lat, 7);
    check("t6_id", res_id, 3);
    check("t6_bcd", res_bcd, 40'h4294967295);
    check("t6_err", res_err, 0);
    tick();
    check("t6_valid_drop", res_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one iterative binary-to-BCD converter between NUM_REQ requesters. Arbitration is round-robin. The block sequences each conversion: capture operand, pulse load, wait for done or timeout, then return the result tagged with the requester ID. It sits between the display/report clients and the single converter instance, so no client drives the converter directly.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
BIN_WIDTH, 32, binary operand width
NUM_DIGITS, 10, BCD digits in result (4 bits each)
TIMEOUT, 1024, max cycles in WAIT before abort (≥2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
req_bin  input  NUM_REQ*BIN_WIDTH  packed operands; requester i uses bits [i*BIN_WIDTH +: BIN_WIDTH]
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_id  output  $clog2(NUM_REQ)  requester index of result
res_bcd  output  NUM_DIGITS*4  BCD result, digit 0 in LSBs
res_err  output  1  1 = conversion timed out, res_bcd is zero
conv_load  output  1  one-cycle start pulse to converter
conv_bin  output  BIN_WIDTH  operand to converter, held from LOAD until return to IDLE
conv_done  input  1  one-cycle completion pulse from converter
conv_bcd  input  NUM_DIGITS*4  converter result, valid while conv_done=1

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all registers 0. req_ready=0, res_valid=0, res_id=0, res_bcd=0, res_err=0, conv_load=0, conv_bin=0.
- FSM states: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - grant = first index i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … with mod NUM_REQ wrap.
  - req_ready[grant]=1 combinationally in the same cycle; all other bits are 0.
  - On that edge: latch grant and req_bin[grant], go to LOAD.
  - No valid requests: stay in IDLE, req_ready=0.
- LOAD: conv_load=1 for exactly one cycle, conv_bin=latched operand. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - conv_done=1: latch conv_bcd into res_bcd, res_err=0, go to RESP.
  - Counter reaches TIMEOUT-1 without done: res_bcd=0, res_err=1, go to RESP.
  - conv_done and timeout in the same cycle: done wins.
- RESP:
  - res_valid=1; res_id, res_bcd and res_err are held stable until res_ready=1.
  - On the handshake edge: rr_ptr=(grant+1) mod NUM_REQ, go to IDLE.
  - res_valid deasserts in the next cycle.
- conv_done outside WAIT is ignored, including a late done after a timeout.
- Latency: accept at cycle T → conv_load at T+1 → conv_done at T+1+L gives res_valid=1 at T+2+L.
- Minimum turnaround with res_ready held high: next accept possible the cycle after the RESP handshake.
- A requester must hold req_valid and req_bin stable until req_ready=1. A dropped request is simply not granted, and there is no error.
- Fairness: a requester that keeps req_valid asserted is granted within NUM_REQ grants.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. Any in-flight conversion result is discarded.
- req_ready is never asserted outside IDLE. conv_load is never asserted outside LOAD.

Test Plan:
- Single request: req_valid[2]=1, req_bin=255; converter model returns done after 5 cycles → conv_load one pulse with conv_bin=255; res_valid 7 cycles after accept; res_id=2, res_bcd=0x...0255, res_err=0.
- All four requesting continuously with res_ready=1 → grant order 0,1,2,3,0,1. Each res_id matches the operand its requester sent (values 10,20,30,40 → BCD 0x10,0x20,0x30,0x40).
- Back-pressure: res_ready=0 for 20 cycles after res_valid → outputs stable; no req_ready asserted; after res_ready=1, rr_ptr advances and the next grant proceeds.
- Timeout: TIMEOUT=16, converter never pulses done → res_valid at the 16th WAIT cycle with res_err=1, res_bcd=0. A late conv_done injected in IDLE → ignored, no spurious res_valid.
- Simultaneous done and timeout on the same cycle → res_err=0 and res_bcd=conv_bcd. A stray conv_done during LOAD or RESP → ignored.
- Async reset asserted during WAIT, then released → all outputs 0; next request from requester 3 with rr_ptr=0 and only req_valid[3]=1 → granted, with a correct result for 4294967295 (0x4294967295).
